wb_buffer: RTL

WB_BUFFER -- requirements
Module: wb_buffer

---
 rtl/wb_pkg.sv | 13 +
 rtl/wb_bypass_match.sv | 38 +++
 rtl/wb_buffer.sv | 103 ++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared widths, default depth and entry layout for the writeback buffer.
package wb_pkg;

    localparam int XLEN          = 32;
    localparam int REG_AW        = 5;
    localparam int DEFAULT_DEPTH = 4;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/wb_bypass_match.sv
// Youngest-match search over the pending entries of the writeback queue.
module wb_bypass_match
    import wb_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    parameter  int XLEN  = wb_pkg::XLEN,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic [PW-1:0]           i_head,
    input  logic [CW-1:0]           i_count,
    input  logic [REG_AW-1:0]       i_rs,
    input  logic [DEPTH*REG_AW-1:0] i_rd_flat,
    input  logic [DEPTH*XLEN-1:0]   i_data_flat,
    output logic                    o_hit,
    output logic [XLEN-1:0]         o_data
);

    logic [PW-1:0] w_idx;
    logic          w_match;

    // Walk oldest to youngest so the last valid match left standing is the youngest.
    always_comb begin
        o_hit   = 1'b0;
        o_data  = {XLEN{1'b0}};
        w_idx   = {PW{1'b0}};
        w_match = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx   = i_head + PW'(k);
            w_match = (CW'(k) < i_count) &&
                      (i_rs != {REG_AW{1'b0}}) &&
                      (i_rd_flat[w_idx*REG_AW +: REG_AW] == i_rs);
            o_hit   = o_hit | w_match;
            o_data  = w_match ? i_data_flat[w_idx*XLEN +: XLEN] : o_data;
        end
    end

endmodule

// File: rtl/wb_buffer.sv
// Circular writeback queue between a result producer and a shared register-file
// write port, with two youngest-wins bypass lookups over the pending entries.
module wb_buffer
    import wb_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    parameter  int XLEN  = wb_pkg::XLEN,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [XLEN-1:0]   in_data,
    input  logic              port_busy,
    output logic              rf_en,
    output logic [REG_AW-1:0] rd,
    output logic [XLEN-1:0]   wdata,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    output logic              byp1_hit,
    output logic              byp2_hit,
    output logic [XLEN-1:0]   byp1_data,
    output logic [XLEN-1:0]   byp2_data,
    output logic [CW-1:0]     count
);

    logic [PW-1:0]           r_head;
    logic [PW-1:0]           r_tail;
    logic [CW-1:0]           r_count;
    logic [DEPTH*REG_AW-1:0] r_mem_rd;
    logic [DEPTH*XLEN-1:0]   r_mem_data;
    logic                    w_push;
    logic                    w_pop;

    // Handshake, drain port and head view; all derived from registered state.
    always_comb begin
        in_ready = (r_count < CW'(DEPTH));
        w_pop    = (r_count != {CW{1'b0}}) && !port_busy;
        w_push   = in_valid && in_ready && (in_rd != {REG_AW{1'b0}});
        rf_en    = w_pop;
        count    = r_count;
        if (r_count != {CW{1'b0}}) begin
            rd    = r_mem_rd[r_head*REG_AW +: REG_AW];
            wdata = r_mem_data[r_head*XLEN +: XLEN];
        end else begin
            rd    = {REG_AW{1'b0}};
            wdata = {XLEN{1'b0}};
        end
    end

    // Pointer and occupancy state; reset alone discards everything pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= {PW{1'b0}};
            r_tail  <= {PW{1'b0}};
            r_count <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PW'(1'b1);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1'b1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1'b1);
                2'b01:   r_count <= r_count - CW'(1'b1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage is unreset; validity comes only from head/count.
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem_rd[r_tail*REG_AW +: REG_AW] <= in_rd;
            r_mem_data[r_tail*XLEN +: XLEN]   <= in_data;
        end
    end

    wb_bypass_match #(.DEPTH(DEPTH), .XLEN(XLEN)) u_byp1 (
        .i_head      (r_head),
        .i_count     (r_count),
        .i_rs        (rs1),
        .i_rd_flat   (r_mem_rd),
        .i_data_flat (r_mem_data),
        .o_hit       (byp1_hit),
        .o_data      (byp1_data)
    );

    wb_bypass_match #(.DEPTH(DEPTH), .XLEN(XLEN)) u_byp2 (
        .i_head      (r_head),
        .i_count     (r_count),
        .i_rs        (rs2),
        .i_rd_flat   (r_mem_rd),
        .i_data_flat (r_mem_data),
        .o_hit       (byp2_hit),
        .o_data      (byp2_data)
    );

endmodule
